block_reducer: RTL

Downstream consumer of the multiplier's product block. On `start` it requests a block read by asserting `EN_blockRead`. It then collects the `VALID_memVal`/`memVal_data` beat stream and reduces it to a sum, maximum, minimum and beat count. The result is presented on a valid/ready handshake for the next stage, with a timeout if the multiplier never starts streaming.

---
 rtl/block_reducer_pkg.sv | 21 ++
 rtl/reducer_stats.sv | 66 ++++++
 rtl/block_reducer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/block_reducer_pkg.sv
// Shared types, default widths and the beat-cap helper for block_reducer.
package block_reducer_pkg;

  localparam int unsigned DEF_LOGDEPTH = 6;
  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_TIMEOUT  = 255;

  // Prefixed names keep these apart from the multiplier's state_t.
  typedef enum logic [1:0] {
    RED_IDLE = 2'd0,
    RED_REQ  = 2'd1,
    RED_RECV = 2'd2,
    RED_DONE = 2'd3
  } reducer_state_t;

  // Maximum number of beats in one block.
  function automatic int unsigned beat_cap(input int unsigned logdepth);
    return 32'd1 << logdepth;
  endfunction

endpackage

// File: rtl/reducer_stats.sv
// Running sum / max / min / count over the accepted beats of one block.
module reducer_stats
  import block_reducer_pkg::*;
#(
  parameter int unsigned LOGDEPTH = DEF_LOGDEPTH,
  parameter int unsigned WIDTH    = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      acc_en,
  input  logic [WIDTH-1:0]          data,
  output logic [WIDTH+LOGDEPTH-1:0] sum,
  output logic [WIDTH-1:0]          max_val,
  output logic [WIDTH-1:0]          min_val,
  output logic [LOGDEPTH:0]         count
);

  localparam int unsigned SW = WIDTH + LOGDEPTH;
  localparam int unsigned CW = LOGDEPTH + 1;

  logic [SW-1:0]    sum_q,   sum_d;
  logic [WIDTH-1:0] max_q,   max_d;
  logic [WIDTH-1:0] min_q,   min_d;
  logic [CW-1:0]    count_q, count_d;

  // Clear wins over accumulate; min restarts at all-ones so the first beat always replaces it.
  always_comb begin
    sum_d   = sum_q;
    max_d   = max_q;
    min_d   = min_q;
    count_d = count_q;
    if (clear) begin
      sum_d   = '0;
      max_d   = '0;
      min_d   = '1;
      count_d = '0;
    end else if (acc_en) begin
      sum_d   = sum_q + SW'(data);
      count_d = count_q + CW'(1);
      if (data > max_q) max_d = data;
      if (data < min_q) min_d = data;
    end
  end

  // Statistic registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      max_q   <= '0;
      min_q   <= '1;
      count_q <= '0;
    end else begin
      sum_q   <= sum_d;
      max_q   <= max_d;
      min_q   <= min_d;
      count_q <= count_d;
    end
  end

  assign sum     = sum_q;
  assign max_val = max_q;
  assign min_val = min_q;
  assign count   = count_q;

endmodule

// File: rtl/block_reducer.sv
// Requests a product block, reduces its beat stream and hands the result downstream.
module block_reducer
  import block_reducer_pkg::*;
#(
  parameter int unsigned LOGDEPTH = DEF_LOGDEPTH,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      EN_blockRead,
  input  logic                      VALID_memVal,
  input  logic [WIDTH-1:0]          memVal_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [WIDTH+LOGDEPTH-1:0] res_sum,
  output logic [WIDTH-1:0]          res_max,
  output logic [WIDTH-1:0]          res_min,
  output logic [LOGDEPTH:0]         res_count,
  output logic                      err_timeout,
  output logic                      err_overrun
);

  localparam int unsigned CW = LOGDEPTH + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  reducer_state_t state_q, state_d;
  logic [TW-1:0]  tmo_q,   tmo_d;
  logic           en_q,    en_d;
  logic           busy_q,  busy_d;
  logic           valid_q, valid_d;
  logic           terr_q,  terr_d;
  logic           oerr_q,  oerr_d;
  logic           clear;
  logic           acc_en;
  logic           cap_hit;
  logic [TW-1:0]  tmo_inc;

  // The beat being accepted this cycle fills the block.
  assign cap_hit = (res_count + CW'(1)) == CW'(beat_cap(LOGDEPTH));
  assign tmo_inc = tmo_q + TW'(1);

  // Next-state, handshake and datapath control.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    en_d    = en_q;
    valid_d = valid_q;
    terr_d  = terr_q;
    oerr_d  = oerr_q;
    clear   = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      RED_IDLE: begin
        if (VALID_memVal) oerr_d = 1'b1;
        if (start) begin
          state_d = RED_REQ;
          clear   = 1'b1;
          terr_d  = 1'b0;
          en_d    = 1'b1;
          tmo_d   = '0;
        end
      end
      RED_REQ: begin
        tmo_d = tmo_inc;
        if (VALID_memVal) begin
          acc_en  = 1'b1;
          en_d    = 1'b0;
          state_d = cap_hit ? RED_DONE : RED_RECV;
          valid_d = cap_hit;
        end else if (tmo_inc == TW'(TIMEOUT)) begin
          en_d    = 1'b0;
          terr_d  = 1'b1;
          state_d = RED_DONE;
          valid_d = 1'b1;
        end
      end
      RED_RECV: begin
        if (VALID_memVal) begin
          acc_en = 1'b1;
          if (cap_hit) begin
            state_d = RED_DONE;
            valid_d = 1'b1;
          end
        end else begin
          state_d = RED_DONE;
          valid_d = 1'b1;
        end
      end
      RED_DONE: begin
        if (VALID_memVal) oerr_d = 1'b1;
        if (res_ready) begin
          state_d = RED_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = RED_IDLE;
    endcase
    busy_d = (state_d != RED_IDLE);
  end

  // State and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RED_IDLE;
      tmo_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      terr_q  <= terr_d;
      oerr_q  <= oerr_d;
    end
  end

  reducer_stats #(
    .LOGDEPTH (LOGDEPTH),
    .WIDTH    (WIDTH)
  ) u_stats (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .acc_en  (acc_en),
    .data    (memVal_data),
    .sum     (res_sum),
    .max_val (res_max),
    .min_val (res_min),
    .count   (res_count)
  );

  assign busy         = busy_q;
  assign EN_blockRead = en_q;
  assign res_valid    = valid_q;
  assign err_timeout  = terr_q;
  assign err_overrun  = oerr_q;

endmodule
